// File: rtl/nn_fifo_ctrl.sv
// Shares the buffer FIFO write port among NUM_REQ producers (rotating priority)
// and streams FIFO chunks to the PE array over valid/ready.
module nn_fifo_ctrl #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_IN_WIDTH  = 16,
  parameter int DATA_OUT_WIDTH = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  input  logic [NUM_REQ*DATA_IN_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]               o_req_ready,
  output logic [$clog2(NUM_REQ)-1:0]       o_grant_id,
  output logic [DATA_IN_WIDTH-1:0]         o_fifo_din,
  output logic                             o_fifo_wr_en,
  input  logic                             i_fifo_full,
  output logic                             o_fifo_rd_en,
  input  logic                             i_fifo_empty,
  input  logic [DATA_OUT_WIDTH-1:0]        i_fifo_dout,
  output logic                             o_out_valid,
  output logic [DATA_OUT_WIDTH-1:0]        o_out_data,
  output logic                             o_out_last,
  input  logic                             i_out_ready,
  output logic [CNT_WIDTH-1:0]             o_wr_count,
  output logic [CNT_WIDTH-1:0]             o_rd_count
);

  // state  | meaning
  // S_IDLE | no chunk pending; wait for FIFO not empty
  // S_READ | one-cycle chunk read strobe
  // S_CAPT | FIFO output register valid; capture chunk and last flag
  // S_HOLD | chunk presented to PE until accepted

  localparam int GW          = $clog2(NUM_REQ);
  localparam int CHUNK_COUNT = DATA_IN_WIDTH / DATA_OUT_WIDTH;
  localparam int CW          = (CHUNK_COUNT > 1) ? $clog2(CHUNK_COUNT) : 1;
  localparam logic [GW-1:0] LAST_REQ   = GW'(NUM_REQ - 1);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNK_COUNT - 1);
  localparam logic [GW:0]   NUM_REQ_W  = (GW + 1)'(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CAPT, S_HOLD} state_t;

  state_t                      r_state, w_state_nxt;
  logic [GW-1:0]               r_prio;
  logic [CW-1:0]               r_chunk_cnt;
  logic [DATA_OUT_WIDTH-1:0]   r_out_data;
  logic                        r_out_last;
  logic [CNT_WIDTH-1:0]        r_wr_count, r_rd_count;

  logic [2*NUM_REQ-1:0]        w_rot;
  logic [GW-1:0]               w_offset, w_grant;
  logic [GW:0]                 w_sum;
  logic [DATA_IN_WIDTH-1:0]    w_din;
  logic                        w_wr_en, w_rd_en, w_capture, w_out_valid, w_hs;

  // Rotate valids so bit k is requester (prio+k) mod NUM_REQ; lowest set bit wins.
  assign w_rot = {i_req_valid, i_req_valid} >> r_prio;

  always_comb begin
    w_offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_offset = GW'(k);
    end
    w_sum = {1'b0, r_prio} + {1'b0, w_offset};
    if (w_sum >= NUM_REQ_W) w_sum = w_sum - NUM_REQ_W;
    w_grant = w_sum[GW-1:0];
  end

  always_comb begin
    w_din = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant == GW'(k)) w_din = i_req_data[k*DATA_IN_WIDTH +: DATA_IN_WIDTH];
    end
  end

  assign w_wr_en = (|i_req_valid) & ~i_fifo_full;

  always_ff @(posedge clk) begin
    if (rst) r_prio <= '0;
    else if (w_wr_en) r_prio <= (w_grant == LAST_REQ) ? '0 : w_grant + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_capture   = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: if (!i_fifo_empty) w_state_nxt = S_READ;
      S_READ: begin
        w_rd_en     = 1'b1;
        w_state_nxt = S_CAPT;
      end
      S_CAPT: begin
        w_capture   = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        w_out_valid = 1'b1;
        if (i_out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_hs = w_out_valid & i_out_ready;

  // chunk_cnt mirrors the FIFO's internal chunk pointer, so only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_chunk_cnt <= '0;
    end else begin
      if (w_capture) begin
        r_out_data <= i_fifo_dout;
        r_out_last <= (r_chunk_cnt == LAST_CHUNK);
      end
      if (w_hs) r_chunk_cnt <= (r_chunk_cnt == LAST_CHUNK) ? '0 : r_chunk_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_count <= '0;
      r_rd_count <= '0;
    end else begin
      if (w_wr_en && (r_wr_count != '1)) r_wr_count <= r_wr_count + 1'b1;
      if (w_hs && (r_rd_count != '1))    r_rd_count <= r_rd_count + 1'b1;
    end
  end

  assign o_req_ready  = w_wr_en ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant) : '0;
  assign o_grant_id   = w_grant;
  assign o_fifo_din   = w_din;
  assign o_fifo_wr_en = w_wr_en;
  assign o_fifo_rd_en = w_rd_en;
  assign o_out_valid  = w_out_valid;
  assign o_out_data   = r_out_data;
  assign o_out_last   = r_out_last;
  assign o_wr_count   = r_wr_count;
  assign o_rd_count   = r_rd_count;

endmodule

// File: tb/tb_nn_fifo_ctrl.sv
// Bench for nn_fifo_ctrl: behavioural 4-word 16->4 FIFO, requester drivers,
// and write/read scoreboards fed by directed stimulus.
module tb_nn_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid, req_ready, req_ready4;
  logic [63:0] req_data;
  logic [1:0]  grant_id, grant_id4;
  logic [15:0] fifo_din, fifo_din4;
  logic        fifo_wr_en, fifo_wr_en4, fifo_full, fifo_rd_en, fifo_rd_en4, fifo_empty;
  logic [3:0]  fifo_dout;
  logic        out_valid, out_valid4, out_last, out_last4, out_ready;
  logic [3:0]  out_data, out_data4;
  logic [15:0] wr_count, rd_count;
  logic [3:0]  wr_count4, rd_count4;

  always #5 clk = ~clk;

  nn_fifo_ctrl u_dut (
    .clk(clk), .rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_grant_id(grant_id), .o_fifo_din(fifo_din),
    .o_fifo_wr_en(fifo_wr_en), .i_fifo_full(fifo_full), .o_fifo_rd_en(fifo_rd_en),
    .i_fifo_empty(fifo_empty), .i_fifo_dout(fifo_dout), .o_out_valid(out_valid),
    .o_out_data(out_data), .o_out_last(out_last), .i_out_ready(out_ready),
    .o_wr_count(wr_count), .o_rd_count(rd_count)
  );

  // Narrow-counter build sharing the same inputs, for saturation.
  nn_fifo_ctrl #(.CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready4), .o_grant_id(grant_id4), .o_fifo_din(fifo_din4),
    .o_fifo_wr_en(fifo_wr_en4), .i_fifo_full(fifo_full), .o_fifo_rd_en(fifo_rd_en4),
    .i_fifo_empty(fifo_empty), .i_fifo_dout(fifo_dout), .o_out_valid(out_valid4),
    .o_out_data(out_data4), .o_out_last(out_last4), .i_out_ready(out_ready),
    .o_wr_count(wr_count4), .o_rd_count(rd_count4)
  );

  // FIFO model: 4 words deep, low chunk first, registered dout.
  logic [15:0] f_mem [4];
  logic [1:0]  f_wp, f_rp, f_cp;
  logic [2:0]  f_cnt;
  always @(posedge clk) begin
    if (rst) begin
      f_wp <= 0; f_rp <= 0; f_cp <= 0; f_cnt <= 0; fifo_dout <= 0;
    end else begin
      if (fifo_wr_en && f_cnt != 3'd4) begin
        f_mem[f_wp] <= fifo_din;
        f_wp <= f_wp + 1'b1;
      end
      if (fifo_rd_en && f_cnt != 3'd0) begin
        fifo_dout <= f_mem[f_rp][f_cp*4 +: 4];
        f_cp <= f_cp + 1'b1;
        if (f_cp == 2'd3) f_rp <= f_rp + 1'b1;
      end
      f_cnt <= f_cnt + 3'(fifo_wr_en && f_cnt != 3'd4)
                     - 3'(fifo_rd_en && f_cnt != 3'd0 && f_cp == 2'd3);
    end
  end
  assign fifo_full  = (f_cnt == 3'd4);
  assign fifo_empty = (f_cnt == 3'd0);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  typedef struct packed {logic [1:0] g; logic [15:0] w;} wr_exp_t;
  typedef struct packed {logic [3:0] d; logic l;} rd_exp_t;
  wr_exp_t     exp_wr [$];
  rd_exp_t     exp_rd [$];
  logic [15:0] q_req [4][$];

  task automatic load(input int i, input logic [15:0] w);
    q_req[i].push_back(w);
  endtask

  task automatic expw(input int g, input logic [15:0] w);
    wr_exp_t x;
    rd_exp_t r;
    x.g = 2'(g);
    x.w = w;
    exp_wr.push_back(x);
    for (int j = 0; j < 4; j++) begin
      r.d = w[4*j +: 4];
      r.l = (j == 3);
      exp_rd.push_back(r);
    end
  endtask

  // Requester drivers: hold valid/data until ready, then present next word.
  logic [3:0] hs;
  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      hs = rst ? 4'b0 : (req_valid & req_ready);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) void'(q_req[i].pop_front());
        if (q_req[i].size() != 0) begin
          req_valid[i] = 1'b1;
          req_data[i*16 +: 16] = q_req[i][0];
        end else begin
          req_valid[i] = 1'b0;
          req_data[i*16 +: 16] = 16'h0;
        end
      end
    end
  end

  wr_exp_t mw;
  always @(negedge clk) begin
    if (!rst && fifo_wr_en) begin
      if (exp_wr.size() == 0) fail_msg("unexpected_write");
      else begin
        mw = exp_wr.pop_front();
        check("grant_id", 32'(grant_id), 32'(mw.g));
        check("req_ready", 32'(req_ready), 32'(4'b0001 << mw.g));
        check("fifo_din", 32'(fifo_din), 32'(mw.w));
      end
    end
  end

  rd_exp_t mr;
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_rd.size() == 0) fail_msg("unexpected_chunk");
      else begin
        mr = exp_rd.pop_front();
        check("out_data", 32'(out_data), 32'(mr.d));
        check("out_last", 32'(out_last), 32'(mr.l));
      end
    end
  end

  logic       st_pend = 1'b0;
  logic [3:0] st_d;
  logic       st_l;
  always @(negedge clk) begin
    if (rst) st_pend = 1'b0;
    else begin
      if (st_pend) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(st_d));
        check("hold_last", 32'(out_last), 32'(st_l));
      end
      st_pend = out_valid && !out_ready;
      st_d    = out_data;
      st_l    = out_last;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_fifo_rd_en", 32'(fifo_rd_en), 0);
    check("rst_wr_count", 32'(wr_count), 0);
    check("rst_rd_count", 32'(rd_count), 0);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input bit toggle);
    int c = 0;
    while ((exp_wr.size() != 0 || exp_rd.size() != 0) && c < max_cyc) begin
      @(posedge clk); #1;
      c++;
      if (toggle && (c % 2 == 0)) out_ready = ~out_ready;
    end
    if (c >= max_cyc) begin
      fail_msg("drain_timeout");
      exp_wr.delete();
      exp_rd.delete();
      for (int i = 0; i < 4; i++) q_req[i].delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cyc);
    int c = 0;
    @(negedge clk);
    while (!out_valid && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    if (!out_valid) fail_msg("wait_valid_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic    [15:0] w;
  rd_exp_t        rx;
  wr_exp_t        wx;
  initial begin
    out_ready = 1'b0;
    do_reset();

    // single word, low chunk first
    out_ready = 1'b1;
    load(0, 16'hABCD); expw(0, 16'hABCD);
    wait_idle(500, 1'b0);
    check("t1_wr_count", 32'(wr_count), 1);
    check("t1_rd_count", 32'(rd_count), 4);

    // all four requesters valid from reset: two rounds 0,1,2,3
    do_reset();
    out_ready = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) begin
        w = {4'(i), 4'(r), 8'hA5};
        load(i, w); expw(i, w);
      end
    wait_idle(1000, 1'b0);
    check("t2_wr_count", 32'(wr_count), 8);
    check("t2_rd_count", 32'(rd_count), 32);

    // fill with reads stalled; pointer frozen at 0 while full
    do_reset();
    out_ready = 1'b0;
    load(0, 16'hF00D); load(1, 16'h1234); load(2, 16'h5678); load(3, 16'h9ABC);
    load(0, 16'hDEF0); load(2, 16'h2468);
    expw(0, 16'hF00D); expw(1, 16'h1234); expw(2, 16'h5678); expw(3, 16'h9ABC);
    expw(0, 16'hDEF0); expw(2, 16'h2468);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("t3_full_wr_count", 32'(wr_count), 4);
    check("t3_full_req_ready", 32'(req_ready), 0);
    check("t3_full_wr_en", 32'(fifo_wr_en), 0);
    check("t3_held_valid", 32'(out_valid), 1);
    check("t3_held_data", 32'(out_data), 32'hD);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle(1000, 1'b0);
    check("t3_wr_count", 32'(wr_count), 6);
    check("t3_rd_count", 32'(rd_count), 24);

    // ready toggling during a 3-word drain; search from 0 skips idle req 0
    do_reset();
    out_ready = 1'b0;
    load(1, 16'h1357); load(2, 16'h2468); load(3, 16'h9ACE);
    expw(1, 16'h1357); expw(2, 16'h2468); expw(3, 16'h9ACE);
    wait_idle(1000, 1'b1);
    out_ready = 1'b1;
    check("t4_wr_count", 32'(wr_count), 3);
    check("t4_rd_count", 32'(rd_count), 12);

    // reset while holding the second chunk of a word
    do_reset();
    out_ready = 1'b0;
    load(0, 16'h5678);
    wx.g = 2'd0; wx.w = 16'h5678; exp_wr.push_back(wx);
    rx.d = 4'h8; rx.l = 1'b0; exp_rd.push_back(rx);
    wait_valid(50);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    wait_valid(50);
    check("t5_second_chunk", 32'(out_data), 32'h7);
    check("t5_pending_rd", 32'(exp_rd.size()), 0);
    do_reset();
    out_ready = 1'b1;
    load(0, 16'h1234); expw(0, 16'h1234);
    wait_idle(500, 1'b0);
    check("t5_wr_count", 32'(wr_count), 1);
    check("t5_rd_count", 32'(rd_count), 4);

    // 18 writes saturate the 4-bit counters
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 4; i++)
        if (!(k == 4 && i >= 2)) begin
          w = {4'(i), 4'(k), 8'h3C};
          load(i, w); expw(i, w);
        end
    wait_idle(3000, 1'b0);
    check("t6_wr_count", 32'(wr_count), 18);
    check("t6_rd_count", 32'(rd_count), 72);
    check("t6_wr_count_sat", 32'(wr_count4), 32'hF);
    check("t6_rd_count_sat", 32'(rd_count4), 32'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
